// File: rtl/expipe_pkg.sv
// expipe_pkg: shared execution-pipeline types for the CDB and its requesters
package expipe_pkg;
   localparam int ROB_IDX_LEN     = 3;
   localparam int EU_IDX_LEN      = 2;
   localparam int EXCEPT_CODE_LEN = 6;
   localparam int FLAGS_LEN       = 4;
   typedef enum logic [EU_IDX_LEN-1:0] {EU_ALU, EU_MULT, EU_DIV, EU_LSU} eu_idx_t;
   typedef struct packed {
      logic [ROB_IDX_LEN-1:0]     rob_idx;
      logic [31:0]                res_value;
      logic                       except_raised;
      logic [EXCEPT_CODE_LEN-1:0] except_code;
      logic [FLAGS_LEN-1:0]       flags;
   } cdb_data_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: circular-priority search with a rotating pointer that advances past each accepted grant
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic [N-1:0]         req,
   input  logic                 en,
   input  logic                 gnt_accept,
   output logic [N-1:0]         gnt_onehot,
   output logic [$clog2(N)-1:0] gnt_idx
);
   localparam int IW = $clog2(N);
   logic [IW-1:0] prio_q;
   logic          hit;
   int            k;
   always_comb begin
      gnt_onehot = '0;
      gnt_idx    = '0;
      hit        = 1'b0;
      k          = 0;
      for (int i = 0; i < N; i++) begin
         k = (int'(prio_q) + i) % N;
         if (en && !hit && req[k]) begin
            hit           = 1'b1;
            gnt_onehot[k] = 1'b1;
            gnt_idx       = IW'(k);
         end
      end
   end
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) prio_q <= '0;
      else if (gnt_accept) prio_q <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin sharing of the common data bus with a one-entry registered broadcast stage
module cdb_arbiter
   import expipe_pkg::*;
#(
   parameter int N_EU         = 4,
   parameter bit SKIP_FLUSHED = 1'b1
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       flush_i,
   input  logic [N_EU-1:0]            eu_valid_i,
   output logic [N_EU-1:0]            eu_ready_o,
   input  cdb_data_t [N_EU-1:0]       eu_data_i,
   output logic                       cdb_valid_o,
   input  logic                       cdb_ready_i,
   output cdb_data_t                  cdb_data_o,
   output logic [$clog2(N_EU)-1:0]    cdb_src_o
);
   localparam int SW = $clog2(N_EU);
   logic            out_valid_q;
   cdb_data_t       out_data_q;
   logic [SW-1:0]   out_src_q;
   logic [SW-1:0]   gnt_idx;
   logic            slot_free;
   logic            en;
   logic            accept;
   // rst_i gates the grant so no unit sees ready while the block is held in reset
   assign slot_free = !out_valid_q || cdb_ready_i;
   assign en        = slot_free && !flush_i && !rst_i;
   assign accept    = |eu_ready_o;
   rr_arbiter #(.N(N_EU)) u_rr (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .req        (eu_valid_i),
      .en         (en),
      .gnt_accept (accept),
      .gnt_onehot (eu_ready_o),
      .gnt_idx    (gnt_idx)
   );
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
      end else if (accept) begin
         out_valid_q <= 1'b1;
         out_data_q  <= eu_data_i[gnt_idx];
         out_src_q   <= gnt_idx;
      end else if ((flush_i && SKIP_FLUSHED) || cdb_ready_i) begin
         out_valid_q <= 1'b0;
      end
   assign cdb_valid_o = out_valid_q;
   assign cdb_data_o  = out_data_q;
   assign cdb_src_o   = out_src_q;
   a_ready_onehot0: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(eu_ready_o));
   a_stall_stable: assert property (@(posedge clk_i) disable iff (rst_i)
      (cdb_valid_o && !cdb_ready_i) |=> $stable(cdb_data_o));
   a_flush_no_gnt: assert property (@(posedge clk_i) disable iff (rst_i) flush_i |-> (eu_ready_o == '0));
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb_cdb_arbiter: directed and randomized checks of cdb_arbiter against a queue-free round-robin model
module tb_cdb_arbiter;
   import expipe_pkg::*;
   localparam int N = 4;
   logic                clk_i = 1'b0;
   logic                rst_i = 1'b1;
   logic                flush_i = 1'b0;
   logic                cdb_ready_i = 1'b1;
   logic                cdb_valid_o;
   logic [N-1:0]        eu_valid_i = '0;
   logic [N-1:0]        eu_ready_o;
   cdb_data_t [N-1:0]   eu_data_i = '0;
   cdb_data_t           cdb_data_o;
   logic [1:0]          cdb_src_o;
   int                  n_cmp = 0;
   int                  n_err = 0;
   int                  m_prio;
   bit                  m_valid;
   cdb_data_t           m_data;
   int                  m_src;

   cdb_arbiter #(.N_EU(N), .SKIP_FLUSHED(1'b1)) dut (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .flush_i     (flush_i),
      .eu_valid_i  (eu_valid_i),
      .eu_ready_o  (eu_ready_o),
      .eu_data_i   (eu_data_i),
      .cdb_valid_o (cdb_valid_o),
      .cdb_ready_i (cdb_ready_i),
      .cdb_data_o  (cdb_data_o),
      .cdb_src_o   (cdb_src_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_prio  = 0;
      m_valid = 1'b0;
      m_data  = '0;
      m_src   = 0;
   endtask

   // Winner per the arbitration rules: nobody when blocked, else first valid unit circularly from m_prio
   function automatic int exp_grant();
      if (rst_i || flush_i || (m_valid && !cdb_ready_i)) return -1;
      for (int i = 0; i < N; i++)
         if (eu_valid_i[(m_prio + i) % N]) return (m_prio + i) % N;
      return -1;
   endfunction

   task automatic step(output int g);
      #1;
      g = exp_grant();
      chk("eu_ready", 64'(eu_ready_o), (g < 0) ? 64'd0 : (64'd1 << g));
      @(posedge clk_i);
      if (rst_i) model_reset();
      else if (g >= 0) begin
         m_valid = 1'b1;
         m_data  = eu_data_i[g];
         m_src   = g;
         m_prio  = (g + 1) % N;
      end else if (flush_i || cdb_ready_i) m_valid = 1'b0;
      @(negedge clk_i);
      chk("cdb_valid", 64'(cdb_valid_o), 64'(m_valid));
      chk("cdb_data", 64'(cdb_data_o), 64'(m_data));
      chk("cdb_src", 64'(cdb_src_o), 64'(m_src));
   endtask

   task automatic cyc();
      int g;
      step(g);
      if (g >= 0) eu_valid_i[g] = 1'b0;
   endtask

   task automatic rand_data(input int i);
      eu_data_i[i].rob_idx       = 3'($urandom);
      eu_data_i[i].res_value     = $urandom;
      eu_data_i[i].except_raised = 1'($urandom);
      eu_data_i[i].except_code   = 6'($urandom);
      eu_data_i[i].flags         = 4'($urandom);
   endtask

   task automatic do_reset();
      @(negedge clk_i);
      rst_i = 1'b1;
      model_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
   endtask

   initial begin
      cdb_data_t held;
      model_reset();
      for (int i = 0; i < N; i++) rand_data(i);
      eu_valid_i = '1;
      @(negedge clk_i);
      chk("rst_ready", 64'(eu_ready_o), 64'd0);
      chk("rst_valid", 64'(cdb_valid_o), 64'd0);
      chk("rst_src", 64'(cdb_src_o), 64'd0);
      chk("rst_data", 64'(cdb_data_o), 64'd0);
      eu_valid_i = '0;
      @(negedge clk_i);
      rst_i = 1'b0;
      // idle
      repeat (5) begin
         cyc();
         chk("idle_valid", 64'(cdb_valid_o), 64'd0);
      end
      // single requester EU2
      eu_data_i[2] = '{rob_idx: 3'd3, res_value: 32'hDEADBEEF, except_raised: 1'b0,
                       except_code: 6'd0, flags: 4'd0};
      eu_valid_i = 4'b0100;
      #1 chk("t2_ready", 64'(eu_ready_o), 64'b0100);
      cyc();
      chk("t2_src", 64'(cdb_src_o), 64'd2);
      chk("t2_value", 64'(cdb_data_o.res_value), 64'hDEADBEEF);
      chk("t2_rob", 64'(cdb_data_o.rob_idx), 64'd3);
      // all valid from reset: 0,1,2,3,0 back to back
      do_reset();
      for (int i = 0; i < 5; i++) begin
         eu_valid_i = '1;
         cyc();
         chk("t3_src", 64'(cdb_src_o), 64'(i % N));
         chk("t3_valid", 64'(cdb_valid_o), 64'd1);
      end
      // backpressure with EU1 and EU3 waiting
      eu_valid_i  = 4'b1010;
      cdb_ready_i = 1'b0;
      held = cdb_data_o;
      repeat (3) begin
         cyc();
         chk("t4_stable", 64'(cdb_data_o), 64'(held));
      end
      cdb_ready_i = 1'b1;
      cyc();
      chk("t4_src", 64'(cdb_src_o), 64'd1);
      // flush after EU0 accept
      do_reset();
      eu_valid_i = 4'b0001;
      cyc();
      flush_i    = 1'b1;
      eu_valid_i = 4'b0110;
      cyc();
      chk("t5_valid", 64'(cdb_valid_o), 64'd0);
      flush_i    = 1'b0;
      eu_valid_i = 4'b1111;
      #1 chk("t5_ptr", 64'(eu_ready_o), 64'b0010);
      cyc();
      // async reset mid-broadcast
      do_reset();
      eu_valid_i = 4'b0011;
      cyc();
      cyc();
      chk("t6_pre", 64'(cdb_valid_o), 64'd1);
      eu_valid_i = 4'b1111;
      rst_i = 1'b1;
      #1;
      chk("t6_valid", 64'(cdb_valid_o), 64'd0);
      chk("t6_ready", 64'(eu_ready_o), 64'd0);
      model_reset();
      @(negedge clk_i);
      rst_i = 1'b0;
      cyc();
      chk("t6_src", 64'(cdb_src_o), 64'd0);
      // randomized traffic
      for (int c = 0; c < 600; c++) begin
         for (int i = 0; i < N; i++)
            if (!eu_valid_i[i] && $urandom_range(1, 0) == 1) begin
               rand_data(i);
               eu_valid_i[i] = 1'b1;
            end
         cdb_ready_i = ($urandom_range(3, 0) != 0);
         flush_i     = ($urandom_range(15, 0) == 0);
         rst_i       = ($urandom_range(63, 0) == 0);
         if (rst_i) model_reset();
         cyc();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
